my_priority_encoder: RTL and testbench
======================================

Name: my_priority_encoder

Overview:
4-to-2 priority encoder. D3 has the highest priority and D0 the lowest. The encoded index of the highest active input is registered on the rising clock edge, together with a valid flag. Sits between raw request/flag lines and downstream logic that needs a binary index of the most urgent request.

Parameters:
REG_OUT, 1, 1 = outputs registered (1-cycle latency); 0 = outputs purely combinational, clk/rst unused for the datapath.

Ports:
clk  input  1  system clock, rising-edge active
rst  input  1  reset, synchronous, active-high
D3  input  1  request 3, highest priority
D2  input  1  request 2
D1  input  1  request 1
D0  input  1  request 0, lowest priority
A1  output  1  encoded index, MSB
A0  output  1  encoded index, LSB
V  output  1  valid: at least one of D3..D0 was high

Interface (already decided):
- One clock, clk.
- Reset rst is synchronous and active-high.
- All registered state changes only on the rising edge of clk.

Behaviour:
- Combinational encode, evaluated every cycle:
  - D3=1 -> {A1,A0}=11, regardless of D2..D0.
  - else D2=1 -> 10.
  - else D1=1 -> 01.
  - else D0=1 -> 00.
  - all inputs 0 -> {A1,A0}=00, V=0.
- V = D3|D2|D1|D0.
- Resulting truth table, index over {D3,D2,D1,D0}:
  - 0000 -> A=00, V=0
  - 0001 -> 00
  - 001x -> 01
  - 01xx -> 10
  - 1xxx -> 11
  - V=1 for every non-zero input.
- REG_OUT=1:
  - A1, A0 and V are flops updated on each rising clk edge from the combinational encode of the inputs sampled at that edge.
  - Latency is exactly 1 cycle; there is no enable and no handshake.
  - A new result is produced every cycle (throughput 1/cycle).
- REG_OUT=0: outputs follow the inputs combinationally with zero latency, and rst has no effect on them.
- Reset (REG_OUT=1):
  - rst=1 at a rising edge forces A1=0, A0=0, V=0, overriding the inputs.
  - Reset dominates when asserted in the same cycle as any input activity.
  - Deasserting rst gives a valid encode at the first rising edge where rst=0.
  - Mid-operation reset clears the outputs on the next edge; no other state is held.
- The all-zero input and the D0-only input both give A=00. Consumers must qualify A with V.
- Inputs are assumed synchronous to clk. No internal synchronizers.
- No X propagation from the design itself: with known inputs, every output is known one cycle after reset.

Optional Feature:
PRIO_ENC_MULTI_EN
- Defined:
  - Adds output port M (1 bit), registered identically to V (same latency, same reset value 0, same REG_OUT handling).
  - M=1 when two or more of D3..D0 are high in the sampled cycle. Examples: 0011 -> M=1; 0100 -> M=0; 1111 -> M=1; 0000 -> M=0.
  - A1/A0/V behaviour is unchanged.
- Undefined: port M does not exist, and no logic is generated for it.

Test Plan:
- Reset: hold rst=1 for 2 cycles with D=1111 -> A=00, V=0 (and M=0 if PRIO_ENC_MULTI_EN). Release rst with D=1111 -> next edge A=11, V=1.
- Exhaustive sweep, REG_OUT=1: apply D3..D0 = 0000 through 1111 in ascending order, one value per cycle. Each result appears one cycle after its input: 0000->00/V0, 0001->00/V1, 0010 and 0011->01, 0100..0111->10, 1000..1111->11.
- Priority override: D=0001 then 1001 then 0101 -> A=00, 11, 10 on successive cycles, V=1 throughout.
- Valid qualification: alternate D=0000 and 0001 -> A stays 00 while V toggles 0,1,0,1.
- Mid-operation reset: D=1000 steady, assert rst for 1 cycle -> A=00/V=0 for exactly that cycle, then A=11/V=1 again.
- REG_OUT=0 build: D=0110 -> A=10, V=1 in the same timestep, with no clock edge required. With PRIO_ENC_MULTI_EN, also M=1 for D=0110 and M=0 for D=0010.

Source files
------------

// File: rtl/my_priority_encoder.sv
// 4-to-2 priority encoder (D3 highest) with optional output register (REG_OUT).
// Define PRIO_ENC_MULTI_EN to add output M, flagging two or more active requests.
module my_priority_encoder #(
  parameter bit REG_OUT = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic D3,
  input  logic D2,
  input  logic D1,
  input  logic D0,
`ifdef PRIO_ENC_MULTI_EN
  output logic M,
`endif
  output logic A1,
  output logic A0,
  output logic V
);

  logic [1:0] enc;
  logic       any;
`ifdef PRIO_ENC_MULTI_EN
  logic       multi;
`endif

  always_comb begin
    enc = 2'b00;
    if (D3)      enc = 2'b11;
    else if (D2) enc = 2'b10;
    else if (D1) enc = 2'b01;
    any = D3 | D2 | D1 | D0;
  end

`ifdef PRIO_ENC_MULTI_EN
  // Any pair of requests active.
  assign multi = (D3 & (D2 | D1 | D0)) | (D2 & (D1 | D0)) | (D1 & D0);
`endif

  generate
    if (REG_OUT) begin : g_reg
      always_ff @(posedge clk) begin
        if (rst) begin
          A1 <= 1'b0;
          A0 <= 1'b0;
          V  <= 1'b0;
`ifdef PRIO_ENC_MULTI_EN
          M  <= 1'b0;
`endif
        end else begin
          A1 <= enc[1];
          A0 <= enc[0];
          V  <= any;
`ifdef PRIO_ENC_MULTI_EN
          M  <= multi;
`endif
        end
      end
    end else begin : g_comb
      // Clock and reset are intentionally unused in the combinational build.
      logic unused_clk_rst;
      assign unused_clk_rst = &{1'b0, clk, rst};
      assign A1 = enc[1];
      assign A0 = enc[0];
      assign V  = any;
`ifdef PRIO_ENC_MULTI_EN
      assign M  = multi;
`endif
    end
  endgenerate

endmodule

// File: tb/tb_my_priority_encoder.sv
// Scoreboard bench: registered instance checked by a queue-driven monitor,
// combinational instance checked directly for zero-latency behaviour.
module tb_my_priority_encoder;

  logic clk;
  logic rst;
  logic d3, d2, d1, d0;
  logic a1, a0, v, m;
  logic c_d3, c_d2, c_d1, c_d0;
  logic c_a1, c_a0, c_v, c_m;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [1:0] a;
    logic       v;
    logic       m;
    string      name;
  } exp_t;

  exp_t sb[$];

  my_priority_encoder #(.REG_OUT(1'b1)) dut (
    .clk(clk), .rst(rst),
    .D3(d3), .D2(d2), .D1(d1), .D0(d0),
`ifdef PRIO_ENC_MULTI_EN
    .M(m),
`endif
    .A1(a1), .A0(a0), .V(v)
  );

  my_priority_encoder #(.REG_OUT(1'b0)) dut_comb (
    .clk(clk), .rst(rst),
    .D3(c_d3), .D2(c_d2), .D1(c_d1), .D0(c_d0),
`ifdef PRIO_ENC_MULTI_EN
    .M(c_m),
`endif
    .A1(c_a1), .A0(c_a0), .V(c_v)
  );

`ifndef PRIO_ENC_MULTI_EN
  assign m   = 1'b0;
  assign c_m = 1'b0;
`endif

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string nm, input logic [1:0] a_act, input logic v_act,
                       input logic m_act, input logic [1:0] a_exp, input logic v_exp,
                       input logic m_exp);
    n_checks++;
    if (a_act !== a_exp || v_act !== v_exp
`ifdef PRIO_ENC_MULTI_EN
        || m_act !== m_exp
`endif
       ) begin
      n_fail++;
      $display("FAIL %s: got A=%b V=%b M=%b, expected A=%b V=%b M=%b",
               nm, a_act, v_act, m_act, a_exp, v_exp, m_exp);
    end
  endtask

  // Monitor: the registered instance presents a result every cycle.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check(e.name, {a1, a0}, v, m, e.a, e.v, e.m);
    end
  end

  task automatic drive(input logic r, input logic [3:0] d, input logic [1:0] a,
                       input logic ve, input logic me, input string nm);
    exp_t e;
    @(negedge clk);
    rst = r;
    {d3, d2, d1, d0} = d;
    e.a = a; e.v = ve; e.m = me; e.name = nm;
    sb.push_back(e);
  endtask

  initial begin
    rst = 1'b1;
    {d3, d2, d1, d0} = 4'b0000;
    {c_d3, c_d2, c_d1, c_d0} = 4'b0000;

    // Reset dominates active inputs, then release.
    drive(1'b1, 4'b1111, 2'b00, 1'b0, 1'b0, "reset_hold0");
    drive(1'b1, 4'b1111, 2'b00, 1'b0, 1'b0, "reset_hold1");
    drive(1'b0, 4'b1111, 2'b11, 1'b1, 1'b1, "reset_release");

    // Ascending sweep.
    drive(1'b0, 4'b0000, 2'b00, 1'b0, 1'b0, "sweep_0000");
    drive(1'b0, 4'b0001, 2'b00, 1'b1, 1'b0, "sweep_0001");
    drive(1'b0, 4'b0010, 2'b01, 1'b1, 1'b0, "sweep_0010");
    drive(1'b0, 4'b0011, 2'b01, 1'b1, 1'b1, "sweep_0011");
    drive(1'b0, 4'b0100, 2'b10, 1'b1, 1'b0, "sweep_0100");
    drive(1'b0, 4'b0101, 2'b10, 1'b1, 1'b1, "sweep_0101");
    drive(1'b0, 4'b0110, 2'b10, 1'b1, 1'b1, "sweep_0110");
    drive(1'b0, 4'b0111, 2'b10, 1'b1, 1'b1, "sweep_0111");
    drive(1'b0, 4'b1000, 2'b11, 1'b1, 1'b0, "sweep_1000");
    drive(1'b0, 4'b1001, 2'b11, 1'b1, 1'b1, "sweep_1001");
    drive(1'b0, 4'b1010, 2'b11, 1'b1, 1'b1, "sweep_1010");
    drive(1'b0, 4'b1011, 2'b11, 1'b1, 1'b1, "sweep_1011");
    drive(1'b0, 4'b1100, 2'b11, 1'b1, 1'b1, "sweep_1100");
    drive(1'b0, 4'b1101, 2'b11, 1'b1, 1'b1, "sweep_1101");
    drive(1'b0, 4'b1110, 2'b11, 1'b1, 1'b1, "sweep_1110");
    drive(1'b0, 4'b1111, 2'b11, 1'b1, 1'b1, "sweep_1111");

    // Priority override.
    drive(1'b0, 4'b0001, 2'b00, 1'b1, 1'b0, "prio_0001");
    drive(1'b0, 4'b1001, 2'b11, 1'b1, 1'b1, "prio_1001");
    drive(1'b0, 4'b0101, 2'b10, 1'b1, 1'b1, "prio_0101");

    // A stays 00 while V distinguishes idle from D0.
    for (int i = 0; i < 4; i++) begin
      if (i % 2 == 0) drive(1'b0, 4'b0000, 2'b00, 1'b0, 1'b0, "vq_idle");
      else            drive(1'b0, 4'b0001, 2'b00, 1'b1, 1'b0, "vq_d0");
    end

    // Single-cycle mid-operation reset.
    drive(1'b0, 4'b1000, 2'b11, 1'b1, 1'b0, "midrst_pre");
    drive(1'b1, 4'b1000, 2'b00, 1'b0, 1'b0, "midrst_hit");
    drive(1'b0, 4'b1000, 2'b11, 1'b1, 1'b0, "midrst_post0");
    drive(1'b0, 4'b1000, 2'b11, 1'b1, 1'b0, "midrst_post1");

    // Drain scoreboard with a bounded wait.
    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
    #2;
    if (sb.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d entries left, expected 0", sb.size());
    end

    // Combinational build: zero latency, reset ignored.
    @(negedge clk);
    rst = 1'b1;
    {c_d3, c_d2, c_d1, c_d0} = 4'b0110;
    #1 check("comb_0110", {c_a1, c_a0}, c_v, c_m, 2'b10, 1'b1, 1'b1);
    {c_d3, c_d2, c_d1, c_d0} = 4'b0010;
    #1 check("comb_0010", {c_a1, c_a0}, c_v, c_m, 2'b01, 1'b1, 1'b0);
    {c_d3, c_d2, c_d1, c_d0} = 4'b1001;
    #1 check("comb_1001", {c_a1, c_a0}, c_v, c_m, 2'b11, 1'b1, 1'b1);
    {c_d3, c_d2, c_d1, c_d0} = 4'b0000;
    #1 check("comb_0000", {c_a1, c_a0}, c_v, c_m, 2'b00, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
